// File: rtl/imem_resp_if.sv
// Fetch request/response channel between the program-counter side (master)
// and the instruction-memory responder (slave).
interface imem_resp_if #(
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/imem_resp.sv
// Instruction-memory responder: one fetch at a time, WAIT_CYC wait states,
// valid/ready response, loader write port. Optional macro: IMEM_PREFETCH_EN.
module imem_resp #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic              clock,
  input  logic              rst,
  imem_resp_if.slave        bus,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);
  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            r_state, w_next;
  logic [3:0]        r_cnt, w_cnt_next;
  logic [DATA_W-1:0] r_addr;
  logic              r_req_ready;
  logic [DATA_W-1:0] r_rsp_data, w_cap_data;
  logic              r_rsp_err, w_cap_err;
  logic              w_hs, w_capture;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: the memory has no reset branch so a loaded program image survives rst.
  always_ff @(posedge clock) begin
    if (load_en) r_mem[load_addr] <= load_data;
  end

  // The direct IDLE->RESP path reads the live request address; WAIT reads the latched one.
  logic [DATA_W-1:0] w_rd_addr, w_rd_word;
  logic [ADDR_W-1:0] w_rd_idx;
  logic              w_rd_err;

  assign w_rd_addr = (r_state == S_IDLE) ? bus.req_addr : r_addr;
  assign w_rd_idx  = w_rd_addr[ADDR_W-1:0];
  assign w_rd_err  = |w_rd_addr[DATA_W-1:ADDR_W];
  // NOTE: a loader write on the read edge is forwarded, giving write-first behaviour.
  assign w_rd_word = (load_en && load_addr == w_rd_idx) ? load_data : r_mem[w_rd_idx];

`ifdef IMEM_PREFETCH_EN
  logic              r_pf_busy, r_pf_valid;
  logic [3:0]        r_pf_cnt;
  logic [DATA_W-1:0] r_pf_addr, r_pf_data;
  logic [DATA_W-1:0] w_pf_next_addr, w_pf_word;
  logic [ADDR_W-1:0] w_pf_idx;
  logic              w_pf_next_ok, w_pf_hit, w_pf_join, w_consume, w_pf_hit_wr;

  assign w_pf_idx       = r_pf_addr[ADDR_W-1:0];
  assign w_pf_hit_wr    = load_en && load_addr == w_pf_idx;
  assign w_pf_word      = w_pf_hit_wr ? load_data : r_mem[w_pf_idx];
  assign w_pf_next_addr = r_addr + 1'b1;
  assign w_pf_next_ok   = ~|w_pf_next_addr[DATA_W-1:ADDR_W];
  assign w_pf_hit       = r_pf_valid && !w_pf_hit_wr && bus.req_addr == r_pf_addr;
  assign w_pf_join      = r_pf_busy && bus.req_addr == r_pf_addr;
  assign w_consume      = (r_state == S_RESP) && bus.rsp_ready;
`endif

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_hs       = 1'b0;
    w_capture  = 1'b0;
    w_cap_data = w_rd_err ? '0 : w_rd_word;
    w_cap_err  = w_rd_err;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid && r_req_ready) begin
          w_hs = 1'b1;
          if (WAIT_CYC == 0) begin
            w_next    = S_RESP;
            w_capture = 1'b1;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = WAIT_INIT;
          end
`ifdef IMEM_PREFETCH_EN
          if (w_pf_hit) begin
            w_next     = S_RESP;
            w_capture  = 1'b1;
            w_cap_data = r_pf_data;
            w_cap_err  = 1'b0;
          end else if (w_pf_join) begin
            w_next     = S_WAIT;
            w_capture  = 1'b0;
            w_cnt_next = r_pf_cnt;
          end
`endif
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next    = S_RESP;
          w_capture = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_req_ready <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_next;
      r_req_ready <= (w_next == S_IDLE);
      if (w_hs) r_addr <= bus.req_addr;
      if (w_capture) begin
        r_rsp_data <= w_cap_data;
        r_rsp_err  <= w_cap_err;
      end
    end
  end

`ifdef IMEM_PREFETCH_EN
  // The buffer runs only while idle; any accepted request either uses or discards it.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_pf_busy  <= 1'b0;
      r_pf_valid <= 1'b0;
      r_pf_cnt   <= '0;
      r_pf_addr  <= '0;
      r_pf_data  <= '0;
    end else if (w_consume) begin
      r_pf_busy  <= !r_rsp_err && w_pf_next_ok;
      r_pf_valid <= 1'b0;
      r_pf_cnt   <= WAIT_INIT;
      r_pf_addr  <= w_pf_next_addr;
    end else if (w_hs) begin
      r_pf_busy  <= 1'b0;
      r_pf_valid <= 1'b0;
    end else if (r_state == S_IDLE && r_pf_busy) begin
      if (r_pf_cnt == 4'd0) begin
        r_pf_data  <= w_pf_word;
        r_pf_valid <= 1'b1;
        r_pf_busy  <= 1'b0;
      end else begin
        r_pf_cnt <= r_pf_cnt - 4'd1;
      end
    end else if (r_pf_valid && w_pf_hit_wr) begin
      r_pf_valid <= 1'b0;
    end
  end
`endif

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_imem_resp.sv
// Directed bench for imem_resp: three instances with WAIT_CYC = 1, 2 and 3
// share clock, reset and the loader bus; cur selects which one a test drives.
module tb_imem_resp;
  logic        clock;
  logic        rst;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [15:0] load_data;
  logic [1:0]  cur;
  logic        t_req_valid;
  logic [15:0] t_req_addr;
  logic        t_rsp_ready;
  logic        o_req_ready, o_rsp_valid, o_rsp_err;
  logic [15:0] o_rsp_data;
  int          vectors;
  int          miscompares;

  imem_resp_if #(.DATA_W(16)) if1 ();
  imem_resp_if #(.DATA_W(16)) if2 ();
  imem_resp_if #(.DATA_W(16)) if3 ();

  imem_resp #(.DATA_W(16), .ADDR_W(8), .WAIT_CYC(1)) dut1 (
    .clock(clock), .rst(rst), .bus(if1),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data));
  imem_resp #(.DATA_W(16), .ADDR_W(8), .WAIT_CYC(2)) dut2 (
    .clock(clock), .rst(rst), .bus(if2),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data));
  imem_resp #(.DATA_W(16), .ADDR_W(8), .WAIT_CYC(3)) dut3 (
    .clock(clock), .rst(rst), .bus(if3),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

  assign if1.req_valid = (cur == 2'd1) && t_req_valid;
  assign if2.req_valid = (cur == 2'd2) && t_req_valid;
  assign if3.req_valid = (cur == 2'd3) && t_req_valid;
  assign if1.req_addr  = t_req_addr;
  assign if2.req_addr  = t_req_addr;
  assign if3.req_addr  = t_req_addr;
  assign if1.rsp_ready = (cur == 2'd1) && t_rsp_ready;
  assign if2.rsp_ready = (cur == 2'd2) && t_rsp_ready;
  assign if3.rsp_ready = (cur == 2'd3) && t_rsp_ready;

  assign o_req_ready = (cur == 2'd3) ? if3.req_ready : (cur == 2'd2) ? if2.req_ready : if1.req_ready;
  assign o_rsp_valid = (cur == 2'd3) ? if3.rsp_valid : (cur == 2'd2) ? if2.rsp_valid : if1.rsp_valid;
  assign o_rsp_data  = (cur == 2'd3) ? if3.rsp_data  : (cur == 2'd2) ? if2.rsp_data  : if1.rsp_data;
  assign o_rsp_err   = (cur == 2'd3) ? if3.rsp_err   : (cur == 2'd2) ? if2.rsp_err   : if1.rsp_err;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [7:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  // Waits (bounded) for req_ready, then handshakes; returns just after edge N.
  task automatic issue(input logic [15:0] a);
    for (int i = 0; i < 20 && o_req_ready !== 1'b1; i++) tick();
    vectors++;
    if (o_req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL issue_ready: req_ready=%b required 1 within 20 cycles", o_req_ready);
    end
    t_req_valid = 1'b1; t_req_addr = a;
    tick();
    t_req_valid = 1'b0; t_req_addr = 16'hDEAD;
  endtask

  task automatic consume();
    t_rsp_ready = 1'b1;
    tick();
    t_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    cur = 2'd1; t_req_valid = 1'b0; t_req_addr = '0; t_rsp_ready = 1'b0;
    #2 rst = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      cur = 2'(c);
      #1;
      vectors++;
      if ({o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_data} !== 19'h0) begin
        miscompares++;
        $display("FAIL reset_outputs dut%0d: rdy=%b vld=%b err=%b data=%h required all 0",
                 c, o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_data);
      end
    end
    cur = 2'd1;
    load_word(8'h05, 16'hA1B2);
    load_word(8'h10, 16'h5555);
    load_word(8'h20, 16'h2020);
    load_word(8'h21, 16'h2121);
    load_word(8'h40, 16'h4040);
    load_word(8'hFF, 16'h0FF0);
    rst = 1'b0;
    #1;
    vectors++;
    if (o_req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b required 0", o_req_ready);
    end
    tick();
    vectors++;
    if (o_req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_edge_ready: got %b required 1", o_req_ready);
    end
  endtask

  task automatic test_basic_and_stall();
    cur = 2'd1;
    issue(16'h0005);
    tick();
    vectors++;
    if (o_rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_early_valid: got %b required 0 at N+1", o_rsp_valid);
    end
    tick();
    vectors++;
    if (o_rsp_valid !== 1'b1 || o_rsp_data !== 16'hA1B2 || o_rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_resp: vld=%b data=%h err=%b required 1 a1b2 0", o_rsp_valid, o_rsp_data, o_rsp_err);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (o_rsp_valid !== 1'b1 || o_rsp_data !== 16'hA1B2 || o_req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: vld=%b data=%h rdy=%b required 1 a1b2 0",
                 i, o_rsp_valid, o_rsp_data, o_req_ready);
      end
    end
    consume();
    vectors++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release: vld=%b rdy=%b required 0 1", o_rsp_valid, o_req_ready);
    end
  endtask

  task automatic test_range();
    logic [15:0] ra [3];
    logic [15:0] ed [3];
    logic        ee [3];
    ra = '{16'h00FF, 16'h0100, 16'h8005};
    ed = '{16'h0FF0, 16'h0000, 16'h0000};
    ee = '{1'b0, 1'b1, 1'b1};
    cur = 2'd1;
    for (int i = 0; i < 3; i++) begin
      issue(ra[i]);
      tick();
      vectors++;
      if (o_rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL range_early_valid %h: got %b required 0", ra[i], o_rsp_valid);
      end
      tick();
      vectors++;
      if (o_rsp_valid !== 1'b1 || o_rsp_data !== ed[i] || o_rsp_err !== ee[i]) begin
        miscompares++;
        $display("FAIL range_resp %h: vld=%b data=%h err=%b required 1 %h %b",
                 ra[i], o_rsp_valid, o_rsp_data, o_rsp_err, ed[i], ee[i]);
      end
      consume();
    end
  endtask

  task automatic test_write_first();
    cur = 2'd3;
    issue(16'h0010);
    tick(); tick(); tick();
    vectors++;
    if (o_rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wf_early_valid: got %b required 0 at N+3", o_rsp_valid);
    end
    load_en = 1'b1; load_addr = 8'h10; load_data = 16'h1234;
    tick();
    load_en = 1'b0;
    vectors++;
    if (o_rsp_valid !== 1'b1 || o_rsp_data !== 16'h1234) begin
      miscompares++;
      $display("FAIL wf_same_edge: vld=%b data=%h required 1 1234", o_rsp_valid, o_rsp_data);
    end
    consume();
    issue(16'h0010);
    tick(); tick(); tick(); tick();
    load_en = 1'b1; load_addr = 8'h10; load_data = 16'h7777;
    tick();
    load_en = 1'b0;
    vectors++;
    if (o_rsp_valid !== 1'b1 || o_rsp_data !== 16'h1234) begin
      miscompares++;
      $display("FAIL wf_late_write: vld=%b data=%h required 1 1234", o_rsp_valid, o_rsp_data);
    end
    consume();
    issue(16'h0010);
    tick(); tick(); tick(); tick();
    vectors++;
    if (o_rsp_valid !== 1'b1 || o_rsp_data !== 16'h7777) begin
      miscompares++;
      $display("FAIL wf_late_write_landed: vld=%b data=%h required 1 7777", o_rsp_valid, o_rsp_data);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    cur = 2'd1;
    issue(16'h0005);
    tick();
    rst = 1'b1;
    #1;
    vectors++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_async: vld=%b rdy=%b required 0 0", o_rsp_valid, o_req_ready);
    end
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_after: vld=%b rdy=%b required 0 1", o_rsp_valid, o_req_ready);
    end
    issue(16'h0005);
    tick(); tick();
    vectors++;
    if (o_rsp_valid !== 1'b1 || o_rsp_data !== 16'hA1B2 || o_rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_mem_kept: vld=%b data=%h err=%b required 1 a1b2 0", o_rsp_valid, o_rsp_data, o_rsp_err);
    end
    consume();
  endtask

  task automatic test_prefetch();
    cur = 2'd2;
    issue(16'h0020);
    tick(); tick();
    vectors++;
    if (o_rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL pf_first_early: got %b required 0 at N+2", o_rsp_valid);
    end
    tick();
    vectors++;
    if (o_rsp_valid !== 1'b1 || o_rsp_data !== 16'h2020) begin
      miscompares++;
      $display("FAIL pf_first_resp: vld=%b data=%h required 1 2020", o_rsp_valid, o_rsp_data);
    end
    consume();
    tick(); tick(); tick();
    issue(16'h0021);
`ifdef IMEM_PREFETCH_EN
    vectors++;
    if (o_rsp_valid !== 1'b1 || o_rsp_data !== 16'h2121 || o_rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL pf_hit: vld=%b data=%h err=%b required 1 2121 0", o_rsp_valid, o_rsp_data, o_rsp_err);
    end
`else
    tick(); tick();
    vectors++;
    if (o_rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL seq_early: got %b required 0 at N+2", o_rsp_valid);
    end
    tick();
    vectors++;
    if (o_rsp_valid !== 1'b1 || o_rsp_data !== 16'h2121) begin
      miscompares++;
      $display("FAIL seq_resp: vld=%b data=%h required 1 2121", o_rsp_valid, o_rsp_data);
    end
`endif
    consume();
    issue(16'h0040);
    tick(); tick();
    vectors++;
    if (o_rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL pf_miss_early: got %b required 0 at N+2", o_rsp_valid);
    end
    tick();
    vectors++;
    if (o_rsp_valid !== 1'b1 || o_rsp_data !== 16'h4040) begin
      miscompares++;
      $display("FAIL pf_miss_resp: vld=%b data=%h required 1 4040", o_rsp_valid, o_rsp_data);
    end
    consume();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic_and_stall();
    test_range();
    test_write_first();
    test_reset_mid();
    test_prefetch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
